audio_tap_capture: RTL and testbench
====================================

# audio_tap_capture

Parametrised capture engine for the audio filter path on `bus_clk`. It holds the IIR coefficient register bank, written byte-wise through a mem_8-style address port. It detects frame edges on an asynchronous LRCLK and captures one or all channels of filter output into an internal FIFO, which is drained by a Xillybus read stream. Over the single-channel tap it adds:
- N channels and sample width
- decimation
- interleaved mode
- frame-atomic overflow handling with status and drop count

## Interface
Parameters:
- NCH, 2: audio channels on `samp_in` (1..4)
- SAMPLE_W, 16: bits per sample and per FIFO word
- DEPTH, 1024: FIFO words, power of two, ≥ 2*NCH
- NCOEF, 5: 16-bit coefficients, byte registers 0..2*NCOEF-1 (NCOEF ≤ 8)

Ports:
- bus_clk  in  1  sole clock
- quiesce  in  1  reset, asynchronous, active-high
- lrclk  in  1  frame clock, asynchronous to bus_clk
- samp_in  in  NCH*SAMPLE_W  channel k at bits [k*SAMPLE_W +: SAMPLE_W], stable ≥4 cycles after lrclk rise
- reg_addr  in  5  register address
- reg_wren  in  1  register write strobe
- reg_wdata  in  8  register write data
- reg_rden  in  1  register read strobe
- reg_rdata  out  8  register read data, 1-cycle latency
- coef  out  NCOEF*16  coefficient k = {reg[2k+1], reg[2k]}
- rd_open  in  1  read stream open; low flushes FIFO
- rd_rden  in  1  FIFO read strobe
- rd_empty  out  1  FIFO empty
- rd_data  out  SAMPLE_W  FIFO data, valid 1 cycle after accepted rd_rden
- rd_eof  out  1  tied 0

## Operation
Registers:
- 0..2*NCOEF-1: coefficient bytes, R/W.
- 16: CTRL, R/W.
  - bit0 EN
  - bit1 MODE (0 single, 1 interleaved)
  - bits[3:2] CHSEL (value ≥ NCH selects ch0)
  - bits[7:4] DEC
- 17: STATUS, read only except the clear below.
  - bit0 OVF, sticky; a write with bit0=1 clears it
  - bit1 = FIFO full
  - bit2 = rd_empty
- 18: DROPS, 8-bit saturating count of dropped frames; any write clears it.
- Other addresses: reads return 0, writes are ignored.

Frame edge path:
- lrclk goes through a 2-flop synchronizer plus a third flop.
- A frame edge is stage2=1 and stage3=0.

Decimation:
- A counter counts edges while EN=1.
- A frame is captured when the counter = DEC; the counter then returns to 0. DEC=0 captures every edge.
- The counter is held at 0 while EN=0.

Sequencer, states IDLE and WRITE:
- IDLE to WRITE on a captured frame edge, but only if free slots ≥ words per frame (1 in single mode, NCH in interleaved). All NCH samples are latched on that edge.
- If free slots are short: the frame is dropped whole, OVF is set, and DROPS is incremented. No partial frame is ever written.
- WRITE writes one word per cycle: ch0 first, ascending. It returns to IDLE after the last word.
- A frame edge arriving while in WRITE is dropped: OVF is set and DROPS is incremented.

FIFO:
- Simultaneous read and write in the same cycle are both honoured.
- rd_rden while empty is ignored and rd_data holds.
- Pointers wrap modulo DEPTH. Full/empty use an extra pointer bit.

Flush:
- rd_open=0 synchronously empties the FIFO and forces IDLE.
- Frame edges during flush are discarded without counting.
- Registers are unaffected.

Changing MODE or CHSEL takes effect at the next captured frame; a frame in progress completes unchanged.

## Timing
Reset values:
- All registers 0, hence coef=0 and EN=0.
- Synchronizer flops and decimation counter 0, sequencer IDLE.
- reg_rdata=0, rd_data=0, rd_empty=1, rd_eof=0.

Latency:
- lrclk rise to frame edge: 2–3 cycles.
- Frame edge in cycle N: word0 written at the end of N+1, last word at the end of N+NCH in interleaved mode.
- rd_empty falls in cycle N+2.
- reg_rdata is updated the cycle after reg_rden; otherwise it holds.
- coef reflects a write the cycle after reg_wren.

quiesce asserted mid-frame aborts the frame. All state returns to reset values immediately.

## Test plan
- Reset, write regs 0..9 = 0x01..0x0A: coef[15:0]=0x0201 and coef[79:64]=0x0A09; reading reg 1 returns 0x02 one cycle after reg_rden.
- CTRL=0x09 (EN, single, CHSEL=2) with NCH=4, samp_in ch2=0x1234: after one lrclk rise, exactly one word 0x1234 is readable and rd_empty returns to 1 after the read.
- CTRL=0x03 (interleaved), NCH=2, ch0=0xAAAA, ch1=0x5555, 3 frames: read order AAAA,5555 repeated 3×; rd_empty falls 2 cycles after the detected edge.
- DEC=3: 12 lrclk rises capture exactly 3 frames; EN toggled 0→1 restarts the count.
- DEPTH=8, interleaved NCH=2, no reads, 5 frames: 4 frames stored, frame 5 dropped whole, STATUS=0x03, DROPS=1; writing 0x01 to STATUS clears OVF only.
- rd_open low for 1 cycle with 6 words queued: rd_empty=1 next cycle, DROPS unchanged; quiesce pulse mid-WRITE: coef=0 and no partial word remains.

Source files
------------

// File: rtl/audio_tap_capture.sv
// Audio tap capture engine: IIR coefficient register bank, LRCLK frame-edge
// detection with decimation, and a frame-atomic sequencer that loads one
// channel (single mode) or all channels (interleaved mode) into a FIFO that
// is drained by a read stream.
//
// Read-stream handshake: a word is accepted on any cycle where rd_rden=1,
// rd_empty=0 and rd_open=1; its data appears on rd_data on the following
// cycle and holds until the next accepted read.
module audio_tap_capture #(
  parameter int NCH      = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 1024,
  parameter int NCOEF    = 5
) (
  input  logic                      bus_clk,
  input  logic                      quiesce,
  input  logic                      lrclk,
  input  logic [NCH*SAMPLE_W-1:0]   samp_in,
  input  logic [4:0]                reg_addr,
  input  logic                      reg_wren,
  input  logic [7:0]                reg_wdata,
  input  logic                      reg_rden,
  output logic [7:0]                reg_rdata,
  output logic [NCOEF*16-1:0]       coef,
  input  logic                      rd_open,
  input  logic                      rd_rden,
  output logic                      rd_empty,
  output logic [SAMPLE_W-1:0]       rd_data,
  output logic                      rd_eof
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NREG = 2 * NCOEF;
  localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);
  localparam logic [4:0] A_CTRL   = 5'd16;
  localparam logic [4:0] A_STATUS = 5'd17;
  localparam logic [4:0] A_DROPS  = 5'd18;

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  // Register bank
  logic [7:0] coef_q [NREG];
  logic [7:0] coef_d [NREG];
  logic [7:0] ctrl_q, ctrl_d;
  logic       ovf_q, ovf_d;
  logic [7:0] drops_q, drops_d;
  logic [7:0] rdata_q, rdata_d;

  // Frame edge and decimation
  logic [2:0] sync_q, sync_d;
  logic [3:0] dec_cnt_q, dec_cnt_d;
  logic       frame_edge, capture;

  // Sequencer and frame latch
  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] samp_q [NCH];
  logic [SAMPLE_W-1:0] samp_d [NCH];
  logic                mode_q, mode_d;
  logic [CW-1:0]       widx_q, widx_d;
  logic [CW-1:0]       chsel_sel;
  logic                start, drop_evt, last_word, fifo_we;
  logic [SAMPLE_W-1:0] wr_word;

  // FIFO
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SAMPLE_W-1:0] rd_data_q, rd_data_d;
  logic [AW:0]         level;
  logic [AW+1:0]       free_slots, need_slots;
  logic                fifo_full, rd_accept;

  // FIFO occupancy: pointers carry one extra wrap bit, so level never exceeds DEPTH
  assign level      = wptr_q - rptr_q;
  assign fifo_full  = level[AW];
  assign rd_empty   = (wptr_q == rptr_q);
  assign free_slots = (AW+2)'(DEPTH) - {1'b0, level};
  assign need_slots = ctrl_q[1] ? (AW+2)'(NCH) : (AW+2)'(1);
  assign rd_accept  = rd_rden & ~rd_empty & rd_open;

  // Edge is the first cycle the synchronised lrclk is seen high
  assign frame_edge = sync_q[1] & ~sync_q[2];
  assign capture    = frame_edge & ctrl_q[0] & rd_open & (dec_cnt_q == ctrl_q[7:4]);
  assign start      = capture & (state_q == S_IDLE) & (free_slots >= need_slots);
  assign drop_evt   = capture & ~start;

  assign reg_rdata = rdata_q;
  assign rd_data   = rd_data_q;
  assign rd_eof    = 1'b0;

  // Coefficient output: word k is the byte pair {2k+1, 2k}
  always_comb begin
    coef = '0;
    for (int k = 0; k < NCOEF; k++) begin
      coef[k*16 +: 16] = {coef_q[2*k+1], coef_q[2*k]};
    end
  end

  // Channel select for single mode; out-of-range selects fall back to ch0
  always_comb begin
    chsel_sel = '0;
    if (int'(ctrl_q[3:2]) < NCH) chsel_sel = CW'(ctrl_q[3:2]);
  end

  // Register writes, sticky overflow flag and saturating drop counter
  always_comb begin
    for (int i = 0; i < NREG; i++) coef_d[i] = coef_q[i];
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (reg_wren) begin
      if (reg_addr < 5'(NREG)) coef_d[reg_addr[RW-1:0]] = reg_wdata;
      if (reg_addr == A_CTRL) ctrl_d = reg_wdata;
      if (reg_addr == A_STATUS && reg_wdata[0]) ovf_d = 1'b0;
      if (reg_addr == A_DROPS) drops_d = 8'd0;
    end
    // A drop in the same cycle as a clear still registers
    if (drop_evt) begin
      ovf_d = 1'b1;
      if (drops_d != 8'hFF) drops_d = drops_d + 8'd1;
    end
  end

  // Register read port: one cycle latency, holds when not reading
  always_comb begin
    rdata_d = rdata_q;
    if (reg_rden) begin
      if (reg_addr < 5'(NREG))       rdata_d = coef_q[reg_addr[RW-1:0]];
      else if (reg_addr == A_CTRL)   rdata_d = ctrl_q;
      else if (reg_addr == A_STATUS) rdata_d = {5'd0, rd_empty, fifo_full, ovf_q};
      else if (reg_addr == A_DROPS)  rdata_d = drops_q;
      else                           rdata_d = 8'd0;
    end
  end

  // Synchroniser shift and decimation counter (held at 0 while disabled)
  always_comb begin
    sync_d    = {sync_q[1:0], lrclk};
    dec_cnt_d = dec_cnt_q;
    if (!ctrl_q[0]) begin
      dec_cnt_d = 4'd0;
    end else if (frame_edge && rd_open) begin
      dec_cnt_d = capture ? 4'd0 : dec_cnt_q + 4'd1;
    end
  end

  // Sequencer next state: flush forces IDLE, frames are written whole
  always_comb begin
    state_d = state_q;
    if (!rd_open) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_WRITE;
        S_WRITE: if (last_word) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer outputs: one FIFO write per WRITE cycle
  always_comb begin
    fifo_we   = (state_q == S_WRITE) & rd_open;
    wr_word   = samp_q[widx_q];
    last_word = ~mode_q | (widx_q == LAST_IDX);
  end

  // Frame latch: samples, mode and first word index are frozen at the edge
  always_comb begin
    for (int k = 0; k < NCH; k++) samp_d[k] = samp_q[k];
    mode_d = mode_q;
    widx_d = widx_q;
    if (start) begin
      for (int k = 0; k < NCH; k++) samp_d[k] = samp_in[k*SAMPLE_W +: SAMPLE_W];
      mode_d = ctrl_q[1];
      widx_d = ctrl_q[1] ? '0 : chsel_sel;
    end else if (state_q == S_WRITE && mode_q) begin
      widx_d = widx_q + CW'(1);
    end
  end

  // FIFO pointers and read data; closing the stream empties the FIFO
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_data_d = rd_data_q;
    if (!rd_open) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (fifo_we) wptr_d = wptr_q + (AW+1)'(1);
      if (rd_accept) begin
        rptr_d    = rptr_q + (AW+1)'(1);
        rd_data_d = mem[rptr_q[AW-1:0]];
      end
    end
  end

  // FIFO storage (not reset; pointers define validity)
  always_ff @(posedge bus_clk) begin
    if (fifo_we) mem[wptr_q[AW-1:0]] <= wr_word;
  end

  // Sequencer state register
  always_ff @(posedge bus_clk or posedge quiesce) begin
    if (quiesce) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // All remaining state flops
  always_ff @(posedge bus_clk or posedge quiesce) begin
    if (quiesce) begin
      for (int i = 0; i < NREG; i++) coef_q[i] <= 8'd0;
      for (int k = 0; k < NCH; k++)  samp_q[k] <= '0;
      ctrl_q    <= 8'd0;
      ovf_q     <= 1'b0;
      drops_q   <= 8'd0;
      rdata_q   <= 8'd0;
      sync_q    <= 3'd0;
      dec_cnt_q <= 4'd0;
      mode_q    <= 1'b0;
      widx_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) coef_q[i] <= coef_d[i];
      for (int k = 0; k < NCH; k++)  samp_q[k] <= samp_d[k];
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      drops_q   <= drops_d;
      rdata_q   <= rdata_d;
      sync_q    <= sync_d;
      dec_cnt_q <= dec_cnt_d;
      mode_q    <= mode_d;
      widx_q    <= widx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_audio_tap_capture.sv
// Bench for audio_tap_capture: register bank, single/interleaved capture,
// decimation, overflow, flush and mid-frame reset, with a frame-level model.
module tb_audio_tap_capture;
  localparam int NCH   = 4;
  localparam int SW    = 16;
  localparam int DEPTH = 16;
  localparam int NCOEF = 5;

  // Clock and DUT signals
  logic bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  logic               quiesce, lrclk;
  logic [NCH*SW-1:0]  samp_in;
  logic [4:0]         reg_addr;
  logic               reg_wren, reg_rden;
  logic [7:0]         reg_wdata, reg_rdata;
  logic [NCOEF*16-1:0] coef;
  logic               rd_open, rd_rden, rd_empty, rd_eof;
  logic [SW-1:0]      rd_data;

  audio_tap_capture #(.NCH(NCH), .SAMPLE_W(SW), .DEPTH(DEPTH), .NCOEF(NCOEF)) dut (
    .bus_clk(bus_clk), .quiesce(quiesce), .lrclk(lrclk), .samp_in(samp_in),
    .reg_addr(reg_addr), .reg_wren(reg_wren), .reg_wdata(reg_wdata),
    .reg_rden(reg_rden), .reg_rdata(reg_rdata), .coef(coef),
    .rd_open(rd_open), .rd_rden(rd_rden), .rd_empty(rd_empty),
    .rd_data(rd_data), .rd_eof(rd_eof)
  );

  // Scoreboard and frame-level reference model
  int checks = 0;
  int errors = 0;
  int n_reads = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] last_exp = '0;
  logic [7:0] m_ctrl = 8'd0;
  int         m_edges = 0;   // edges seen since capture was enabled
  bit         m_ovf = 1'b0;
  int         m_drops = 0;
  logic [7:0] m_coef [2*NCOEF];
  bit         mon_pending = 1'b0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [79:0] m_coef_vec();
    logic [79:0] v = '0;
    for (int k = 0; k < NCOEF; k++) v[k*16 +: 16] = {m_coef[2*k+1], m_coef[2*k]};
    return v;
  endfunction

  function automatic logic [7:0] m_status();
    return {5'd0, exp_q.size() == 0, exp_q.size() == DEPTH, m_ovf};
  endfunction

  // Every (DEC+1)th edge after enabling is a frame; it is stored whole or not at all
  task automatic model_rise(input logic [NCH*SW-1:0] s);
    int need, ch;
    if (m_ctrl[0] && rd_open) begin
      m_edges++;
      if (m_edges % (int'(m_ctrl[7:4]) + 1) == 0) begin
        need = m_ctrl[1] ? NCH : 1;
        if (DEPTH - exp_q.size() >= need) begin
          if (m_ctrl[1]) begin
            for (int k = 0; k < NCH; k++) exp_q.push_back(s[k*SW +: SW]);
          end else begin
            ch = (int'(m_ctrl[3:2]) < NCH) ? int'(m_ctrl[3:2]) : 0;
            exp_q.push_back(s[ch*SW +: SW]);
          end
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  endtask

  // Monitor: an accepted read produces a word on rd_data one cycle later
  always @(negedge bus_clk) begin
    if (mon_pending) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
      end else begin
        last_exp = exp_q.pop_front();
        n_reads++;
        check("rd_data", rd_data, last_exp);
      end
    end
    mon_pending = rd_rden && !rd_empty && rd_open && !quiesce;
  end

  // Driver tasks
  task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
    @(posedge bus_clk); #1;
    reg_addr = a; reg_wdata = d; reg_wren = 1'b1;
    @(posedge bus_clk); #1;
    reg_wren = 1'b0;
    if (a < 5'(2*NCOEF)) m_coef[a] = d;
    if (a == 5'd16) begin
      m_ctrl = d;
      if (!d[0]) m_edges = 0;
    end
    if (a == 5'd17 && d[0]) m_ovf = 1'b0;
    if (a == 5'd18) m_drops = 0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [7:0] d);
    @(posedge bus_clk); #1;
    reg_addr = a; reg_rden = 1'b1;
    @(posedge bus_clk); #1;
    reg_rden = 1'b0;
    d = reg_rdata;
  endtask

  task automatic frame(input logic [NCH*SW-1:0] s, input bit lat);
    int first;
    @(posedge bus_clk); #1;
    samp_in = s;
    lrclk = 1'b1;
    model_rise(s);
    if (lat) begin
      first = 0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge bus_clk); #1;
        if (first == 0 && !rd_empty) first = c;
      end
      check("edge_to_nonempty", first, 4);
    end else begin
      repeat (8) @(posedge bus_clk);
      #1;
    end
    lrclk = 1'b0;
    repeat (8) @(posedge bus_clk);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge bus_clk); #1;
      if (rd_empty) begin
        rd_rden = 1'b0;
        done = 1'b1;
      end else begin
        rd_rden = 1'b1;
      end
    end
    rd_rden = 1'b0;
    check("drain_done", done, 1);
    repeat (2) @(posedge bus_clk);
    #1;
    check("drain_leftover", exp_q.size(), 0);
  endtask

  function automatic logic [NCH*SW-1:0] rand_samp();
    return {$urandom, $urandom};
  endfunction

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    logic [7:0] rd;
    logic [NCH*SW-1:0] s;
    int r0, nf;
    for (int i = 0; i < 2*NCOEF; i++) m_coef[i] = 8'd0;
    quiesce = 1'b1; lrclk = 1'b0; samp_in = '0;
    reg_addr = '0; reg_wren = 1'b0; reg_wdata = '0; reg_rden = 1'b0;
    rd_open = 1'b1; rd_rden = 1'b0;
    repeat (3) @(posedge bus_clk);
    #1;
    quiesce = 1'b0;
    @(posedge bus_clk); #1;
    check("rst_reg_rdata", reg_rdata, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_empty", rd_empty, 1);
    check("rst_rd_eof", rd_eof, 0);
    check("rst_coef", coef, 0);

    // Coefficient bank
    for (int i = 0; i < 2*NCOEF; i++) reg_write(5'(i), 8'(i + 1));
    check("coef0", coef[15:0], 16'h0201);
    check("coef4", coef[79:64], 16'h0A09);
    check("coef_all", coef, m_coef_vec());
    reg_read(5'd1, rd);  check("rd_reg1", rd, 8'h02);
    reg_read(5'd9, rd);  check("rd_reg9", rd, m_coef[9]);
    reg_write(5'd12, 8'h55);
    reg_read(5'd12, rd); check("rd_unmapped", rd, 8'h00);
    @(posedge bus_clk); #1;
    check("rdata_hold", reg_rdata, 8'h00);
    reg_read(5'd16, rd); check("rd_ctrl_rst", rd, 8'h00);

    // Single mode, channel 2
    reg_write(5'd16, 8'h09);
    s = rand_samp();
    s[2*SW +: SW] = 16'h1234;
    frame(s, 1'b1);
    drain();
    check("single_word", last_exp, 16'h1234);
    check("single_empty", rd_empty, 1);

    // Interleaved, three frames
    reg_write(5'd16, 8'h03);
    s = rand_samp();
    s[0 +: SW]  = 16'hAAAA;
    s[SW +: SW] = 16'h5555;
    frame(s, 1'b1);
    frame(s, 1'b0);
    frame(s, 1'b0);
    drain();

    // Read while empty leaves rd_data unchanged
    @(posedge bus_clk); #1; rd_rden = 1'b1;
    @(posedge bus_clk); #1; rd_rden = 1'b0;
    check("empty_read_hold", rd_data, last_exp);

    // Decimation by 4, then restart on re-enable
    reg_write(5'd16, 8'h00);
    reg_write(5'd16, 8'h31);
    r0 = n_reads;
    for (int i = 0; i < 12; i++) frame(rand_samp(), 1'b0);
    drain();
    check("dec_frames", n_reads - r0, 3);
    frame(rand_samp(), 1'b0);
    frame(rand_samp(), 1'b0);
    reg_write(5'd16, 8'h30);
    reg_write(5'd16, 8'h31);
    r0 = n_reads;
    for (int i = 0; i < 3; i++) frame(rand_samp(), 1'b0);
    drain();
    check("dec_restart_none", n_reads - r0, 0);
    frame(rand_samp(), 1'b0);
    drain();
    check("dec_restart_one", n_reads - r0, 1);

    // Overflow: five interleaved frames without reading
    reg_write(5'd16, 8'h00);
    reg_write(5'd16, 8'h03);
    for (int i = 0; i < 5; i++) frame(rand_samp(), 1'b0);
    reg_read(5'd17, rd); check("ovf_status", rd, m_status());
    check("ovf_status_const", rd, 8'h03);
    reg_read(5'd18, rd); check("ovf_drops", rd, 8'(m_drops));
    reg_write(5'd17, 8'h01);
    reg_read(5'd17, rd); check("ovf_cleared", rd, m_status());
    reg_read(5'd18, rd); check("drops_kept", rd, 8'(m_drops));

    // Flush for one cycle, then edges during a longer flush
    @(posedge bus_clk); #1; rd_open = 1'b0;
    exp_q.delete();
    @(posedge bus_clk); #1; rd_open = 1'b1;
    check("flush_empty", rd_empty, 1);
    @(posedge bus_clk); #1; rd_open = 1'b0;
    frame(rand_samp(), 1'b0);
    frame(rand_samp(), 1'b0);
    @(posedge bus_clk); #1; rd_open = 1'b1;
    repeat (4) @(posedge bus_clk);
    #1;
    check("flush_edges_empty", rd_empty, 1);
    reg_read(5'd18, rd); check("flush_drops", rd, 8'(m_drops));
    reg_read(5'd17, rd); check("flush_status", rd, m_status());
    check("flush_coef", coef, m_coef_vec());

    // Randomised frames with random mode, channel, decimation and reads
    for (int it = 0; it < 24; it++) begin
      reg_write(5'd16, 8'h00);
      reg_write(5'd16, {4'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'b1});
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) frame(rand_samp(), 1'b0);
      if ($urandom_range(0, 2) == 0) drain();
    end
    reg_read(5'd17, rd); check("rand_status", rd, m_status());
    reg_read(5'd18, rd); check("rand_drops", rd, 8'(m_drops));
    drain();

    // Reset in the middle of an interleaved frame write
    reg_write(5'd16, 8'h00);
    reg_write(5'd16, 8'h03);
    @(posedge bus_clk); #1;
    samp_in = rand_samp();
    lrclk = 1'b1;
    repeat (5) @(posedge bus_clk);
    #1;
    quiesce = 1'b1;
    exp_q.delete();
    m_ctrl = 8'd0; m_edges = 0; m_ovf = 1'b0; m_drops = 0;
    for (int i = 0; i < 2*NCOEF; i++) m_coef[i] = 8'd0;
    #1;
    check("qui_empty", rd_empty, 1);
    check("qui_coef", coef, 0);
    @(posedge bus_clk); #1;
    quiesce = 1'b0;
    lrclk = 1'b0;
    repeat (6) @(posedge bus_clk);
    #1;
    check("qui_empty_after", rd_empty, 1);
    reg_read(5'd16, rd); check("qui_ctrl", rd, m_ctrl);
    reg_read(5'd17, rd); check("qui_status", rd, m_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
